// File: rtl/mil_tx_queued.sv
// rtl/mil_tx_queued.sv - MIL-STD-1553 Manchester II word transmitter with push queue
// Words wait in a FIFO and are serialised under bus grant; all timing derives from clk.
module mil_tx_queued #(
  parameter int HALFBIT_CYCLES = 50,
  parameter int DEPTH          = 8,
  parameter int GAP_BITS       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic                     push_type,
  input  logic [15:0]              push_data,
  input  logic                     grant,
  output logic                     request,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     tx_p,
  output logic                     tx_n,
  output logic                     tx_en,
  output logic                     word_done
);
  localparam int AW         = $clog2(DEPTH);
  localparam int CW         = $clog2(HALFBIT_CYCLES);
  localparam int GAP_CYCLES = GAP_BITS * 2 * HALFBIT_CYCLES;
  localparam int GW         = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(HALFBIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop;
  logic          start_cond;
  logic          go;
  logic          hb_end;
  logic          word_end;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [5:0]    hidx;
  logic [5:0]    hidx_next;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   word_data;
  logic          word_type;
  logic          word_par;
  logic          head_type;
  logic [15:0]   head_data;
  logic          first_hb;
  logic          next_hb;

  // Line level (1 = high half) for half-bit idx of a word: 6 sync, 32 data, 2 parity.
  function automatic logic halfbit(input logic typ, input logic [15:0] d,
                                   input logic par, input logic [5:0] idx);
    logic [5:0] rel;
    logic       b;
    logic       r;
    rel = idx - 6'd6;
    b   = (idx >= 6'd38) ? par : d[4'd15 - rel[4:1]];
    if (idx < 6'd6) r = typ ? (idx < 6'd3) : (idx >= 6'd3);
    else            r = rel[0] ? ~b : b;
    return r;
  endfunction

  function automatic logic [2:0] phase_of(input logic [5:0] idx);
    logic [2:0] s;
    if (idx < 6'd6)       s = S_SYNC;
    else if (idx < 6'd38) s = S_DATA;
    else                  s = S_PARITY;
    return s;
  endfunction

  assign push_ready = (level != FULL);
  assign push_fire  = push_valid && push_ready;
  assign request    = (level != '0);
  assign busy       = (state != S_IDLE);
  assign start_cond = request && grant;
  assign {head_type, head_data} = mem[rd_ptr];
  assign hb_end     = (cnt == CNT_LAST);
  assign hidx_next  = hidx + 6'd1;
  assign word_end   = (state == S_SYNC || state == S_DATA || state == S_PARITY)
                      && hb_end && (hidx == 6'd39);
  assign pop        = (state == S_IDLE && go) || (word_end && start_cond);
  assign first_hb   = halfbit(head_type, head_data, ~^head_data, 6'd0);
  assign next_hb    = halfbit(word_type, word_data, word_par, hidx_next);

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= {push_type, push_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // Grant is sampled into go; the pop and first sync half-bit happen on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      go        <= 1'b0;
      cnt       <= '0;
      hidx      <= '0;
      gap_cnt   <= '0;
      word_data <= '0;
      word_type <= 1'b0;
      word_par  <= 1'b0;
      tx_p      <= 1'b0;
      tx_n      <= 1'b0;
      tx_en     <= 1'b0;
      word_done <= 1'b0;
    end else begin
      go        <= 1'b0;
      word_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state     <= S_SYNC;
            cnt       <= '0;
            hidx      <= '0;
            word_type <= head_type;
            word_data <= head_data;
            word_par  <= ~^head_data;
            tx_en     <= 1'b1;
            tx_p      <= first_hb;
            tx_n      <= ~first_hb;
          end else begin
            go <= start_cond;
          end
        end
        S_SYNC, S_DATA, S_PARITY: begin
          if (!hb_end) begin
            cnt <= cnt + 1'b1;
          end else if (hidx != 6'd39) begin
            cnt   <= '0;
            hidx  <= hidx_next;
            state <= phase_of(hidx_next);
            tx_p  <= next_hb;
            tx_n  <= ~next_hb;
          end else begin
            cnt       <= '0;
            hidx      <= '0;
            word_done <= 1'b1;
            if (start_cond) begin
              state     <= S_SYNC;
              word_type <= head_type;
              word_data <= head_data;
              word_par  <= ~^head_data;
              tx_p      <= first_hb;
              tx_n      <= ~first_hb;
            end else begin
              state   <= S_GAP;
              gap_cnt <= '0;
              tx_p    <= 1'b0;
              tx_n    <= 1'b0;
              tx_en   <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mil_tx_queued.sv
// tb/tb_mil_tx_queued.sv - randomized self-checking bench for mil_tx_queued
// Expected line patterns come from a word-level Manchester model and a push-order queue.
module tb_mil_tx_queued;
  localparam int HB       = 4;
  localparam int DEPTH    = 4;
  localparam int GAPB     = 2;
  localparam int WORD_CYC = 40 * HB;
  localparam int GAP_CYC  = GAPB * 2 * HB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid;
  logic        push_ready;
  logic        push_type;
  logic [15:0] push_data;
  logic        grant;
  logic        request;
  logic        busy;
  logic [2:0]  level;
  logic        tx_p;
  logic        tx_n;
  logic        tx_en;
  logic        word_done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];

  mil_tx_queued #(.HALFBIT_CYCLES(HB), .DEPTH(DEPTH), .GAP_BITS(GAPB)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_type(push_type), .push_data(push_data), .grant(grant), .request(request),
    .busy(busy), .level(level), .tx_p(tx_p), .tx_n(tx_n), .tx_en(tx_en),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sync pattern, then each data bit MSB first as {b, ~b}, then the odd-parity bit.
  function automatic logic [39:0] model_pattern(input logic [16:0] w);
    logic [39:0] p;
    logic        odd;
    p = w[16] ? 40'b111000 : 40'b000111;
    for (int i = 15; i >= 0; i--) p = {p[37:0], w[i], ~w[i]};
    odd = 1'b1;
    for (int i = 0; i < 16; i++) odd = odd ^ w[i];
    p = {p[37:0], odd, ~odd};
    return p;
  endfunction

  task automatic push_word(input logic typ, input logic [15:0] d);
    int w;
    w = 0;
    push_valid = 1'b1;
    push_type  = typ;
    push_data  = d;
    while (push_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("push_ready_wait", push_ready, 1);
    @(negedge clk);
    push_valid = 1'b0;
    exp_q.push_back({typ, d});
  endtask

  // Called at a negedge; the current sample is the first cycle of the word once tx_en is seen.
  task automatic expect_word(input int max_wait, input string tag);
    logic [16:0] w;
    logic [39:0] obs;
    int          waited;
    int          bad;
    w      = exp_q.pop_front();
    waited = 0;
    while (tx_en !== 1'b1 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start"}, tx_en, 1);
    if (tx_en !== 1'b1) return;
    bad = 0;
    obs = '0;
    for (int k = 0; k < WORD_CYC; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) push_valid = 1'b0;
      if (k % HB == 0) obs[39 - k / HB] = tx_p;
      else if (tx_p !== obs[39 - k / HB]) bad++;
      if (tx_en !== 1'b1 || tx_n !== ~tx_p) bad++;
      if (k > 0 && word_done !== 1'b0) bad++;
    end
    check({tag, "_pattern"}, obs, model_pattern(w));
    check({tag, "_shape"}, bad, 0);
    @(negedge clk);
    check({tag, "_word_done"}, word_done, 1);
  endtask

  task automatic expect_gap(input string tag);
    int len;
    int bad;
    len = 0;
    bad = 0;
    while (busy === 1'b1 && len < 200) begin
      if (tx_en | tx_p | tx_n) bad++;
      len++;
      @(negedge clk);
    end
    check({tag, "_gap_len"}, len, GAP_CYC);
    check({tag, "_gap_line"}, bad, 0);
  endtask

  task automatic idle_watch(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tx_en | tx_p | tx_n | word_done) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    logic [16:0] rw;
    logic [16:0] w5;
    int          n;
    int          w;

    push_valid = 1'b0;
    push_type  = 1'b0;
    push_data  = '0;
    grant      = 1'b0;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_push_ready", push_ready, 1);
    check("rst_request", request, 0);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_line", {tx_p, tx_n, tx_en}, 0);
    check("rst_word_done", word_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single command word
    grant = 1'b1;
    push_word(1'b1, 16'h02A1);
    expect_word(5, "t1");
    expect_gap("t1");

    // Contiguous command + data
    push_word(1'b1, 16'h02A1);
    push_word(1'b0, 16'h02A1);
    expect_word(5, "t2a");
    expect_word(0, "t2b");
    expect_gap("t2");

    // Grant delayed
    grant = 1'b0;
    rw = 17'($urandom);
    push_word(rw[16], rw[15:0]);
    check("t3_request", request, 1);
    check("t3_level", level, 1);
    idle_watch(600, "t3_idle");
    check("t3_level_held", level, 1);
    grant = 1'b1;
    @(negedge clk);
    check("t3_lat_tx_en", tx_en, 0);
    check("t3_lat_level", level, 1);
    @(negedge clk);
    check("t3_start_tx_en", tx_en, 1);
    check("t3_start_level", level, 0);
    expect_word(0, "t3");
    expect_gap("t3");

    // Full queue, fifth word held until the first pop
    grant = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      rw = 17'($urandom);
      push_word(rw[16], rw[15:0]);
    end
    check("t4_full_ready", push_ready, 0);
    check("t4_full_level", level, DEPTH);
    w5 = 17'($urandom);
    push_valid = 1'b1;
    push_type  = w5[16];
    push_data  = w5[15:0];
    @(negedge clk);
    check("t4_held_level", level, DEPTH);
    grant = 1'b1;
    @(negedge clk);
    check("t4_go_ready", push_ready, 0);
    @(negedge clk);
    check("t4_pop_ready", push_ready, 1);
    check("t4_pop_level", level, DEPTH - 1);
    exp_q.push_back(w5);
    for (int j = 0; j < DEPTH + 1; j++) expect_word(0, "t4");
    expect_gap("t4");

    // Grant dropped during the first of two words
    grant = 1'b0;
    rw = 17'($urandom);
    push_word(rw[16], rw[15:0]);
    rw = 17'($urandom);
    push_word(rw[16], rw[15:0]);
    grant = 1'b1;
    @(negedge clk);
    @(negedge clk);
    grant = 1'b0;
    expect_word(0, "t5a");
    expect_gap("t5a");
    check("t5_level", level, 1);
    check("t5_request", request, 1);
    idle_watch(40, "t5_idle");
    grant = 1'b1;
    @(negedge clk);
    check("t5_lat_tx_en", tx_en, 0);
    @(negedge clk);
    expect_word(0, "t5b");
    expect_gap("t5b");

    // Randomized bursts
    for (int it = 0; it < 6; it++) begin
      grant = 1'b0;
      n = int'($urandom_range(1, DEPTH));
      for (int j = 0; j < n; j++) begin
        rw = 17'($urandom);
        push_word(rw[16], rw[15:0]);
      end
      check("rnd_level", level, n);
      check("rnd_ready", push_ready, (n != DEPTH));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      grant = 1'b1;
      expect_word(3, "rnd_first");
      for (int j = 1; j < n; j++) expect_word(0, "rnd_next");
      expect_gap("rnd");
    end

    // Reset at half-bit 20 with a second word queued
    grant = 1'b1;
    rw = 17'($urandom);
    push_word(rw[16], rw[15:0]);
    rw = 17'($urandom);
    push_word(rw[16], rw[15:0]);
    w = 0;
    while (tx_en !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("t6_started", tx_en, 1);
    repeat (20 * HB) @(negedge clk);
    check("t6_mid_tx_en", tx_en, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_line", {tx_p, tx_n, tx_en}, 0);
    check("t6_rst_level", level, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", push_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle_watch(100, "t6_after_idle");
    check("t6_after_request", request, 0);
    rw = 17'($urandom);
    push_word(rw[16], rw[15:0]);
    expect_word(5, "t6_new");
    expect_gap("t6_new");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
